elastic_buffer: RTL and testbench

- Parametrised successor to the 2-entry skid buffer: a DEPTH-entry valid/ready elastic buffer with fully registered outputs (m_data, m_valid, s_ready, level, almost_full).
- Sits on UART/MVM byte and word streams between producer and consumer stages, where more than one entry of slack is needed to absorb consumer stalls.
- Adds a synchronous flush, an occupancy output and an almost-full flag.

---
 rtl/elastic_buffer.sv | 121 ++++++++++++
 tb/tb_elastic_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/elastic_buffer.sv
// -----------------------------------------------------------------------------
// elastic_buffer
//
// DEPTH-entry valid/ready elastic buffer for byte and word streams. It absorbs
// consumer stalls with more than one entry of slack. Every output is a flop
// loaded from next-state values, so no input reaches an output combinationally.
//
// Parameters
//   WIDTH  data width in bits
//   DEPTH  entry capacity; a power of two from 2 to 64
//   AFULL  almost_full threshold in entries, from 1 to DEPTH
//
// Ports
//   clk          clock
//   rstn         asynchronous, active-low reset
//   flush        synchronous clear of all contents; wins over push and pop
//   s_valid      upstream data valid
//   s_data       upstream data
//   s_ready      buffer can accept (registered)
//   m_valid      head entry valid (registered)
//   m_data       head entry (registered); holds its last value when empty
//   m_ready      downstream accepts
//   level        occupancy 0..DEPTH (registered)
//   almost_full  level >= AFULL (registered)
// -----------------------------------------------------------------------------
module elastic_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         s_valid,
  input  logic [WIDTH-1:0]             s_data,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [WIDTH-1:0]             m_data,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0]    count, count_nxt;
  logic             push, pop, bypass;
  logic [WIDTH-1:0] head_nxt;

  // Handshakes use the registered s_ready/m_valid. Because s_ready is low
  // whenever the buffer is full, there is no same-cycle push-through at full.
  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  // NOTE: every signal this block writes gets a default first, so that no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      // The pointers wrap modulo DEPTH on their own, because DEPTH is a power of two.
      if (push) wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_nxt = count + LW'(1);
        2'b01:   count_nxt = count - LW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // The next head entry is normally already in memory. When the buffer is
  // empty, or holds one entry that is being popped, the next head is the entry
  // being written in this same cycle, so s_data is forwarded to m_data.
  assign bypass   = push && (wr_ptr == rd_ptr_nxt);
  assign head_nxt = bypass ? s_data : mem[rd_ptr_nxt];

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample the same pre-edge values, and the simulation matches the hardware.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      s_ready     <= (count_nxt != DEPTH_L);
      m_valid     <= (count_nxt != '0);
      almost_full <= (count_nxt >= AFULL_L);
      // m_data is loaded only when a valid head will exist. When the buffer
      // goes empty, m_data keeps its last value and stale memory never reaches it.
      if (count_nxt != '0) m_data <= head_nxt;
    end
  end

  // NOTE: the storage array has no reset. Validity is tracked by count and the
  // pointers, so clearing the data would only add reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= s_data;
  end

  // count is itself a flop, so level is still a registered output.
  assign level = count;

endmodule

// File: tb/tb_elastic_buffer.sv
// -----------------------------------------------------------------------------
// tb_elastic_buffer
//
// Directed bench for elastic_buffer with WIDTH=8, DEPTH=4, AFULL=3.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point. A queue holds the entries that should be in the buffer.
// After each edge the queue gives the expected level, flags and head. Fixed
// hand-computed checks are added at the key points.
// -----------------------------------------------------------------------------
module tb_elastic_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [LW-1:0]    level;
  logic             almost_full;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  logic [WIDTH-1:0] q[$];

  always #5 clk = ~clk;

  elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .level       (level),
    .almost_full (almost_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge. Before the edge the model applies the handshakes;
  // after the edge every output is compared with the model.
  task automatic cycle();
    bit do_push, do_pop;
    do_push = s_valid && s_ready;
    do_pop  = m_valid && m_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (do_pop && q.size() != 0) begin
        check("pop_data", 32'(m_data), 32'(q[0]));
        void'(q.pop_front());
        pops++;
      end
      if (do_push) q.push_back(s_data);
    end
    @(posedge clk); #1;
    check("level",       32'(level),       32'(q.size()));
    check("m_valid",     32'(m_valid),     32'(q.size() != 0));
    check("s_ready",     32'(s_ready),     32'(q.size() != DEPTH));
    check("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
    if (q.size() != 0) check("m_data", 32'(m_data), 32'(q[0]));
  endtask

  initial begin
    bit acc;
    int nxt;

    // Reset, then release it with s_valid low.
    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready),     32'd0);
    check("rst_m_valid", 32'(m_valid),     32'd0);
    check("rst_level",   32'(level),       32'd0);
    check("rst_afull",   32'(almost_full), 32'd0);
    check("rst_m_data",  32'(m_data),      32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_s_ready", 32'(s_ready), 32'd1);
    check("rel_m_valid", 32'(m_valid), 32'd0);
    check("rel_level",   32'(level),   32'd0);

    // Push into an empty buffer: the entry appears one cycle after it is accepted.
    s_valid = 1'b1; s_data = 8'hA1; m_ready = 1'b1;
    cycle();
    check("lat_m_valid", 32'(m_valid), 32'd1);
    check("lat_m_data",  32'(m_data),  32'hA1);
    s_valid = 1'b0;
    cycle();
    check("lat_level0",  32'(level),   32'd0);

    // Fill with the consumer stalled. 0x05 is held until s_ready returns.
    m_ready = 1'b0; s_valid = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      s_data = 8'(d);
      cycle();
      check("fill_head", 32'(m_data), 32'h01);
      if (d == 2) check("fill_af2", 32'(almost_full), 32'd0);
      if (d == 3) check("fill_af3", 32'(almost_full), 32'd1);
    end
    check("full_level",   32'(level),   32'd4);
    check("full_s_ready", 32'(s_ready), 32'd0);
    s_data = 8'h05;
    cycle();
    cycle();
    check("full_hold_level", 32'(level),  32'd4);
    check("full_hold_head",  32'(m_data), 32'h01);

    // Drain from full with the source still pushing. s_ready rises after the first pop.
    m_ready = 1'b1;
    acc = s_ready;
    cycle();
    if (acc) s_data = s_data + 8'd1;
    check("drain_s_ready", 32'(s_ready), 32'd1);
    check("drain_head",    32'(m_data),  32'h02);
    check("drain_level",   32'(level),   32'd3);
    for (int i = 0; i < 6; i++) begin
      acc = s_ready;
      cycle();
      if (acc) s_data = s_data + 8'd1;
    end
    check("flow_level", 32'(level), 32'd3);

    // Flush at level 3, together with a push of 0x77 and a pop.
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
    cycle();
    check("flush_level",   32'(level),   32'd0);
    check("flush_m_valid", 32'(m_valid), 32'd0);
    check("flush_s_ready", 32'(s_ready), 32'd1);
    flush = 1'b0; s_valid = 1'b0;
    cycle();
    cycle();
    check("post_flush_m_valid", 32'(m_valid), 32'd0);

    // Stream 0x00..0xFF with random s_valid and m_ready.
    pops = 0;
    nxt  = 0;
    for (int c = 0; c < 5000 && pops < 256; c++) begin
      s_valid = (nxt < 256) && ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 1) == 1);
      s_data  = 8'(nxt);
      acc     = s_valid && s_ready;
      cycle();
      if (acc) nxt++;
    end
    check("stream_pops",   32'(pops), 32'd256);
    check("stream_pushes", 32'(nxt),  32'd256);

    // Assert reset asynchronously while the buffer holds data.
    s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b0;
    cycle();
    cycle();
    check("pre_arst_level", 32'(level), 32'd2);
    #2 rstn = 1'b0;
    #1;
    check("arst_s_ready", 32'(s_ready),     32'd0);
    check("arst_m_valid", 32'(m_valid),     32'd0);
    check("arst_level",   32'(level),       32'd0);
    check("arst_afull",   32'(almost_full), 32'd0);
    check("arst_m_data",  32'(m_data),      32'd0);
    q.delete();
    s_valid = 1'b0;
    @(negedge clk) rstn = 1'b1;
    cycle();
    check("arst_rel_s_ready", 32'(s_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
